// File: rtl/pcm_delay_line.sv
// Programmable 0..15-sample PCM delay; output registered, latency delay+1 advancing edges.
// No backpressure; with DELAY_LINE_CE_EN, sample_en gates every state update.
module pcm_delay_line #(
  parameter int DATA_W  = 19,
  parameter int DELAY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef DELAY_LINE_CE_EN
  input  logic               sample_en,
`endif
  input  logic [DELAY_W-1:0] delay,
  input  logic [DATA_W-1:0]  pcm_data,
  output logic [DATA_W-1:0]  delayed_pcm_data
);

  localparam int DEPTH = 2 ** DELAY_W;

  logic [DATA_W-1:0] tap [DEPTH];
  logic [DATA_W-1:0] sel_dat;
  logic              advance;

`ifdef DELAY_LINE_CE_EN
  assign advance = sample_en;
`else
  assign advance = 1'b1;
`endif

  // delay==0 bypasses the history so the output register alone gives one cycle.
  always_comb begin
    sel_dat = pcm_data;
    if (delay != '0) begin
      sel_dat = tap[delay - DELAY_W'(1)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        tap[k] <= '0;
      end
      delayed_pcm_data <= '0;
    end else if (advance) begin
      tap[0] <= pcm_data;
      for (int k = 1; k < DEPTH; k++) begin
        tap[k] <= tap[k-1];
      end
      delayed_pcm_data <= sel_dat;
    end
  end

endmodule

// File: tb/tb_pcm_delay_line.sv
// Directed bench for pcm_delay_line: reset, zero/max delay, delay switch, bit-exact sweep.
// Build with DELAY_LINE_CE_EN defined to also exercise the sample_en gating.
module tb_pcm_delay_line;

  localparam int DATA_W  = 19;
  localparam int DELAY_W = 4;

  logic               clk;
  logic               rst;
  logic [DELAY_W-1:0] delay;
  logic [DATA_W-1:0]  pcm_data;
  logic [DATA_W-1:0]  delayed_pcm_data;
`ifdef DELAY_LINE_CE_EN
  logic               sample_en;
`endif

  int tests_run;
  int tests_failed;

  pcm_delay_line #(.DATA_W(DATA_W), .DELAY_W(DELAY_W)) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef DELAY_LINE_CE_EN
    .sample_en        (sample_en),
`endif
    .delay            (delay),
    .pcm_data         (pcm_data),
    .delayed_pcm_data (delayed_pcm_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset asynchronously away from the clock edge.
  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    tick();
    #1 rst = 1'b1;
  endtask

  logic [DATA_W-1:0] hist [$];
  logic [DATA_W-1:0] v;
  logic [DATA_W-1:0] exp_v;
  int                n;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b0;
    delay    = '0;
    pcm_data = 19'h7FFFF;
`ifdef DELAY_LINE_CE_EN
    sample_en = 1'b1;
`endif

    // Reset held: output stays 0 despite all-ones input.
    tick();
    chk("rst_hold0", delayed_pcm_data, '0);
    tick();
    chk("rst_hold1", delayed_pcm_data, '0);
    #2 rst = 1'b1;
    tick();
    chk("rst_release", delayed_pcm_data, 19'h7FFFF);

    // Mid-cycle reset clears the output without a clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_async", delayed_pcm_data, '0);
    tick();
    chk("rst_async_hold", delayed_pcm_data, '0);
    #1 rst = 1'b1;

    // Zero delay: output is the input of the previous edge.
    delay = 4'd0;
    for (int i = 1; i <= 8; i++) begin
      pcm_data = DATA_W'(i);
      tick();
      chk("zero_delay", delayed_pcm_data, DATA_W'(i));
    end

    // Max delay: 100 appears on the 16th edge after it was applied.
    apply_reset();
    delay = 4'd15;
    for (int i = 0; i < 20; i++) begin
      pcm_data = DATA_W'(100 + i);
      tick();
      chk("max_delay", delayed_pcm_data, (i >= 15) ? DATA_W'(100 + i - 15) : '0);
    end

    // Delay switch 3 -> 10 at input 50: jumps back to 40, no flush.
    apply_reset();
    delay = 4'd3;
    for (int vi = 1; vi <= 52; vi++) begin
      if (vi == 50) delay = 4'd10;
      pcm_data = DATA_W'(vi);
      tick();
      if (vi == 49) chk("switch_before", delayed_pcm_data, 19'd46);
      if (vi == 50) chk("switch_jump", delayed_pcm_data, 19'd40);
      if (vi == 51) chk("switch_after", delayed_pcm_data, 19'd41);
    end

    // Bit-exact sweep over every delay, history carried across delay changes.
    apply_reset();
    hist.delete();
    for (int d = 0; d < 16; d++) begin
      delay = DELAY_W'(d);
      for (int c = 0; c < 1000; c++) begin
        if (c % 97 == 5)      v = 19'h40000;
        else if (c % 89 == 7) v = 19'h3FFFF;
        else                  v = DATA_W'($urandom);
        hist.push_back(v);
        pcm_data = v;
        tick();
        n = hist.size() - 1;
        exp_v = (n >= d) ? hist[n-d] : '0;
        chk("bit_exact", delayed_pcm_data, exp_v);
      end
    end

`ifdef DELAY_LINE_CE_EN
    // sample_en every 4th clock, delay 2, inputs 7..10 on enabled edges.
    apply_reset();
    delay = 4'd2;
    begin
      logic [DATA_W-1:0] held;
      int                k;
      held = '0;
      k    = 0;
      for (int c = 0; c < 16; c++) begin
        sample_en = (c % 4 == 3);
        pcm_data  = sample_en ? DATA_W'(7 + k) : 19'h55555;
        if (sample_en && k == 3) chk("ce_before_10", delayed_pcm_data, 19'd7);
        tick();
        if (sample_en) begin
          held = (k >= 2) ? DATA_W'(7 + k - 2) : '0;
          k++;
        end
        chk("ce_hold", delayed_pcm_data, held);
      end
      sample_en = 1'b1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
